id_ex_register: RTL and testbench
=================================

Name: id_ex_register

Overview:
- Pipeline register between the ID stage and the EX stage of the 5-stage MIPS core.
- Captures the decoded instruction fields, the register-file read data and the 32-bit extended immediate produced by ID_sign_extend, plus the control bundle.
- Handles hazard-unit stall (hold) and flush (bubble insertion), and the debug-unit step enable.
- Keeps a saturating count of the bubbles it has inserted, read by the debug unit.

Parameters:
- NB_DATA, 32, width of the datapath, PC+4, read data and extended immediate.
- NB_REG, 5, width of a register-file address (rs, rt, rd, shamt).
- NB_FUNCT, 6, width of the funct field.
- NB_CTRL, 12, width of the packed control bundle; bit positions are defined in the package.
- NB_CNT, 16, width of the bubble counter.

Ports:
- i_clk  in  1  system clock, rising edge.
- i_reset  in  1  synchronous reset, active-high.
- i_enable  in  1  debug step enable; 0 freezes the stage.
- i_stall  in  1  hazard unit: hold the current contents.
- i_flush  in  1  hazard unit: load a bubble.
- i_valid  in  1  ID holds a real instruction.
- i_pc_plus4  in  NB_DATA  PC+4 of the ID instruction.
- i_read_data1  in  NB_DATA  register-file port 1 data.
- i_read_data2  in  NB_DATA  register-file port 2 data.
- i_sign_extend  in  NB_DATA  extended immediate from ID_sign_extend.
- i_rs, i_rt, i_rd, i_shamt  in  NB_REG each  instruction fields.
- i_funct  in  NB_FUNCT  funct field.
- i_ctrl  in  NB_CTRL  control bundle from the control unit.
- o_* for every data, field and control input above  out  same width  registered copies.
- o_valid  out  1  EX holds a real instruction.
- o_bubble_count  out  NB_CNT  saturating count of bubbles loaded.

Behaviour:
- Clocking and reset: one clock, i_clk; i_reset is synchronous and active-high, sampled on the rising edge.
- Reset: all outputs become 0, including o_valid, o_ctrl and o_bubble_count.
- Priority at each rising edge: reset > !i_enable (freeze) > flush > stall > load.
- Freeze (i_enable=0): every register holds, and flush is ignored. The hazard unit keeps i_flush asserted while the core is frozen, because flush is a function of frozen state.
- Flush (i_enable=1, i_flush=1): every output is zeroed and o_valid=0.
  - Flush takes priority over a simultaneous stall.
  - Bubble counter increments.
- Stall (i_enable=1, i_flush=0, i_stall=1): every register holds, and the counter holds.
- Load (i_enable=1, i_flush=0, i_stall=0):
  - Data and field outputs capture their inputs.
  - o_valid <= i_valid.
  - o_ctrl <= i_valid ? i_ctrl : 0. An invalid instruction never carries a write-enable or memory-access bit.
  - If i_valid=0 the load counts as a bubble and the counter increments.
- Latency: exactly 1 cycle from input to output on load; no combinational path from input to output.
- Bubble counter: increments by 1 per bubble event and saturates at 2^NB_CNT-1; it does not wrap. Only reset clears it.
- Reset asserted mid-stall or mid-freeze: reset wins; the next cycle is a normal load if enable=1 and stall=0.
- Immediate: passed through unchanged. This stage performs no width conversion or sign handling.

Decomposition:
- Package id_ex_pkg:
  - CTRL_* bit indices: REG_WRITE, MEM_TO_REG, MEM_READ, MEM_WRITE, BRANCH, REG_DST, ALU_SRC, ALU_OP[2:0], JUMP, JAL.
  - Width localparams.
- Sub-module pipe_field_reg, instantiated once per field group.
  - Parameter: WIDTH.
  - Inputs: i_clk, i_reset, i_hold, i_clear, i_d.
  - Output: o_q.
  - Priority: reset > hold > clear > load.
  - i_hold is !i_enable | (i_stall & !i_flush); i_clear is i_flush.
- Valid bit, ctrl gating and bubble counter live in the top module.

Test Plan:
1. Reset: assert i_reset for 2 cycles with all inputs 0xFFFF_FFFF -> every output 0, o_bubble_count=0.
2. Load: i_valid=1, i_sign_extend=0xFFFF_8000, i_read_data1=0x1234_5678, i_ctrl=0x0A5 -> exactly one cycle later o_sign_extend=0xFFFF_8000, o_read_data1=0x1234_5678, o_ctrl=0x0A5, o_valid=1.
3. Stall: load pc_plus4=0x40, then i_stall=1 for 3 cycles while pc_plus4 changes to 0x44 -> o_pc_plus4 stays 0x40 and the counter is unchanged; after stall is released, o_pc_plus4=0x44.
4. Flush with simultaneous stall: i_flush=1, i_stall=1 -> o_ctrl=0, o_valid=0, counter +1. A second case, i_valid=0 with i_ctrl=0xFFF -> o_ctrl=0 and counter +1.
5. Freeze: i_enable=0 with i_flush=1 for 4 cycles -> outputs and counter unchanged; raising enable with flush still high -> bubble loaded, counter +1.
6. Saturation: NB_CNT=4, drive 20 consecutive flushes -> o_bubble_count reaches 15 and stays at 15.

Source files
------------

// File: rtl/id_ex_pkg.sv
// Shared widths and control-bundle bit positions for the ID/EX pipeline register.
package id_ex_pkg;

    localparam int NB_DATA  = 32;
    localparam int NB_REG   = 5;
    localparam int NB_FUNCT = 6;
    localparam int NB_CTRL  = 12;
    localparam int NB_CNT   = 16;

    localparam int CTRL_REG_WRITE  = 0;
    localparam int CTRL_MEM_TO_REG = 1;
    localparam int CTRL_MEM_READ   = 2;
    localparam int CTRL_MEM_WRITE  = 3;
    localparam int CTRL_BRANCH     = 4;
    localparam int CTRL_REG_DST    = 5;
    localparam int CTRL_ALU_SRC    = 6;
    localparam int CTRL_ALU_OP_LSB = 7;
    localparam int CTRL_ALU_OP_MSB = 9;
    localparam int CTRL_JUMP       = 10;
    localparam int CTRL_JAL        = 11;

    // An invalid slot must never carry write-enable or memory-access bits.
    function automatic logic [NB_CTRL-1:0] ctrl_gate(input logic valid, input logic [NB_CTRL-1:0] ctrl);
        logic [NB_CTRL-1:0] gated;
        if (valid) begin
            gated = ctrl;
        end else begin
            gated = {NB_CTRL{1'b0}};
        end
        return gated;
    endfunction

endpackage

// File: rtl/id_ex_register_pipe_field_reg.sv
// One group of pipeline flops with reset > hold > clear > load priority.
module pipe_field_reg #(
    parameter int WIDTH = 1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_hold,
    input  logic             i_clear,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    // Field register update
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_q <= {WIDTH{1'b0}};
        end else if (i_hold) begin
            r_q <= r_q;
        end else if (i_clear) begin
            r_q <= {WIDTH{1'b0}};
        end else begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/id_ex_register.sv
// ID/EX pipeline register with stall, flush, debug freeze and a saturating bubble counter.
module id_ex_register
    import id_ex_pkg::*;
#(
    parameter int P_NB_DATA  = NB_DATA,
    parameter int P_NB_REG   = NB_REG,
    parameter int P_NB_FUNCT = NB_FUNCT,
    parameter int P_NB_CTRL  = NB_CTRL,
    parameter int P_NB_CNT   = NB_CNT
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_enable,
    input  logic                  i_stall,
    input  logic                  i_flush,
    input  logic                  i_valid,
    input  logic [P_NB_DATA-1:0]  i_pc_plus4,
    input  logic [P_NB_DATA-1:0]  i_read_data1,
    input  logic [P_NB_DATA-1:0]  i_read_data2,
    input  logic [P_NB_DATA-1:0]  i_sign_extend,
    input  logic [P_NB_REG-1:0]   i_rs,
    input  logic [P_NB_REG-1:0]   i_rt,
    input  logic [P_NB_REG-1:0]   i_rd,
    input  logic [P_NB_REG-1:0]   i_shamt,
    input  logic [P_NB_FUNCT-1:0] i_funct,
    input  logic [P_NB_CTRL-1:0]  i_ctrl,
    output logic [P_NB_DATA-1:0]  o_pc_plus4,
    output logic [P_NB_DATA-1:0]  o_read_data1,
    output logic [P_NB_DATA-1:0]  o_read_data2,
    output logic [P_NB_DATA-1:0]  o_sign_extend,
    output logic [P_NB_REG-1:0]   o_rs,
    output logic [P_NB_REG-1:0]   o_rt,
    output logic [P_NB_REG-1:0]   o_rd,
    output logic [P_NB_REG-1:0]   o_shamt,
    output logic [P_NB_FUNCT-1:0] o_funct,
    output logic [P_NB_CTRL-1:0]  o_ctrl,
    output logic                  o_valid,
    output logic [P_NB_CNT-1:0]   o_bubble_count
);

    localparam int NB_DGRP = 4 * P_NB_DATA;
    localparam int NB_FGRP = 4 * P_NB_REG + P_NB_FUNCT;

    logic                 w_hold;
    logic                 w_clear;
    logic                 w_bubble;
    logic [P_NB_CTRL-1:0] w_ctrl_gated;
    logic [NB_DGRP-1:0]   w_data_q;
    logic [NB_FGRP-1:0]   w_field_q;
    logic [P_NB_CNT-1:0]  r_bubble_count;

    // Flush beats stall; freeze beats both.
    assign w_hold       = !i_enable | (i_stall & !i_flush);
    assign w_clear      = i_flush;
    assign w_bubble     = i_enable & (i_flush | (!i_stall & !i_valid));
    assign w_ctrl_gated = P_NB_CTRL'(ctrl_gate(i_valid, NB_CTRL'(i_ctrl)));

    pipe_field_reg #(.WIDTH(NB_DGRP)) u_data_reg (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_hold  (w_hold),
        .i_clear (w_clear),
        .i_d     ({i_pc_plus4, i_read_data1, i_read_data2, i_sign_extend}),
        .o_q     (w_data_q)
    );

    pipe_field_reg #(.WIDTH(NB_FGRP)) u_field_reg (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_hold  (w_hold),
        .i_clear (w_clear),
        .i_d     ({i_rs, i_rt, i_rd, i_shamt, i_funct}),
        .o_q     (w_field_q)
    );

    pipe_field_reg #(.WIDTH(P_NB_CTRL)) u_ctrl_reg (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_hold  (w_hold),
        .i_clear (w_clear),
        .i_d     (w_ctrl_gated),
        .o_q     (o_ctrl)
    );

    pipe_field_reg #(.WIDTH(1)) u_valid_reg (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_hold  (w_hold),
        .i_clear (w_clear),
        .i_d     (i_valid),
        .o_q     (o_valid)
    );

    assign {o_pc_plus4, o_read_data1, o_read_data2, o_sign_extend} = w_data_q;
    assign {o_rs, o_rt, o_rd, o_shamt, o_funct}                    = w_field_q;

    // Saturating bubble counter, cleared only by reset
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_bubble_count <= {P_NB_CNT{1'b0}};
        end else if (w_bubble && (r_bubble_count != {P_NB_CNT{1'b1}})) begin
            r_bubble_count <= r_bubble_count + {{(P_NB_CNT-1){1'b0}}, 1'b1};
        end else begin
            r_bubble_count <= r_bubble_count;
        end
    end

    assign o_bubble_count = r_bubble_count;

endmodule

// File: tb/tb_id_ex_register.sv
// Directed bench for id_ex_register: default instance plus a 4-bit-counter instance for saturation.
module tb_id_ex_register;

    logic        clk;
    logic        reset, enable, stall, flush, valid;
    logic [31:0] pc_plus4, read_data1, read_data2, sign_extend;
    logic [4:0]  rs, rt, rd, shamt;
    logic [5:0]  funct;
    logic [11:0] ctrl;

    logic [31:0] o_pc_plus4, o_read_data1, o_read_data2, o_sign_extend;
    logic [4:0]  o_rs, o_rt, o_rd, o_shamt;
    logic [5:0]  o_funct;
    logic [11:0] o_ctrl;
    logic        o_valid;
    logic [15:0] o_bubble_count;

    logic [31:0] s_pc_plus4, s_read_data1, s_read_data2, s_sign_extend;
    logic [4:0]  s_rs, s_rt, s_rd, s_shamt;
    logic [5:0]  s_funct;
    logic [11:0] s_ctrl;
    logic        s_valid;
    logic [3:0]  s_bubble_count;

    int checks   = 0;
    int failures = 0;
    int exp_cnt  = 0;
    int exp_sat  = 0;

    id_ex_register dut (
        .i_clk(clk), .i_reset(reset), .i_enable(enable), .i_stall(stall), .i_flush(flush),
        .i_valid(valid), .i_pc_plus4(pc_plus4), .i_read_data1(read_data1),
        .i_read_data2(read_data2), .i_sign_extend(sign_extend), .i_rs(rs), .i_rt(rt),
        .i_rd(rd), .i_shamt(shamt), .i_funct(funct), .i_ctrl(ctrl),
        .o_pc_plus4(o_pc_plus4), .o_read_data1(o_read_data1), .o_read_data2(o_read_data2),
        .o_sign_extend(o_sign_extend), .o_rs(o_rs), .o_rt(o_rt), .o_rd(o_rd),
        .o_shamt(o_shamt), .o_funct(o_funct), .o_ctrl(o_ctrl), .o_valid(o_valid),
        .o_bubble_count(o_bubble_count)
    );

    id_ex_register #(.P_NB_CNT(4)) dut_sat (
        .i_clk(clk), .i_reset(reset), .i_enable(enable), .i_stall(stall), .i_flush(flush),
        .i_valid(valid), .i_pc_plus4(pc_plus4), .i_read_data1(read_data1),
        .i_read_data2(read_data2), .i_sign_extend(sign_extend), .i_rs(rs), .i_rt(rt),
        .i_rd(rd), .i_shamt(shamt), .i_funct(funct), .i_ctrl(ctrl),
        .o_pc_plus4(s_pc_plus4), .o_read_data1(s_read_data1), .o_read_data2(s_read_data2),
        .o_sign_extend(s_sign_extend), .o_rs(s_rs), .o_rt(s_rt), .o_rd(s_rd),
        .o_shamt(s_shamt), .o_funct(s_funct), .o_ctrl(s_ctrl), .o_valid(s_valid),
        .o_bubble_count(s_bubble_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
        end
    endtask

    // Advance one rising edge; inputs and samples both sit 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // 1. Reset with every input driven high
        reset = 1'b1; enable = 1'b1; stall = 1'b1; flush = 1'b1; valid = 1'b1;
        pc_plus4 = 32'hFFFF_FFFF; read_data1 = 32'hFFFF_FFFF;
        read_data2 = 32'hFFFF_FFFF; sign_extend = 32'hFFFF_FFFF;
        rs = 5'h1F; rt = 5'h1F; rd = 5'h1F; shamt = 5'h1F; funct = 6'h3F; ctrl = 12'hFFF;
        step();
        step();
        check("rst_pc", o_pc_plus4, 32'h0);
        check("rst_rd1", o_read_data1, 32'h0);
        check("rst_rd2", o_read_data2, 32'h0);
        check("rst_sext", o_sign_extend, 32'h0);
        check("rst_fields", {o_rs, o_rt, o_rd, o_shamt, o_funct}, 32'h0);
        check("rst_ctrl", {20'h0, o_ctrl}, 32'h0);
        check("rst_valid", {31'h0, o_valid}, 32'h0);
        check("rst_cnt", {16'h0, o_bubble_count}, 32'h0);

        // 2. Load with one-cycle latency
        reset = 1'b0; stall = 1'b0; flush = 1'b0; valid = 1'b1;
        pc_plus4 = 32'h0; read_data1 = 32'h1234_5678; read_data2 = 32'hCAFE_0001;
        sign_extend = 32'hFFFF_8000; ctrl = 12'h0A5;
        rs = 5'd3; rt = 5'd17; rd = 5'd31; shamt = 5'd9; funct = 6'h21;
        #1;
        check("no_comb_sext", o_sign_extend, 32'h0);
        check("no_comb_valid", {31'h0, o_valid}, 32'h0);
        step();
        check("ld_sext", o_sign_extend, 32'hFFFF_8000);
        check("ld_rd1", o_read_data1, 32'h1234_5678);
        check("ld_rd2", o_read_data2, 32'hCAFE_0001);
        check("ld_ctrl", {20'h0, o_ctrl}, 32'h0A5);
        check("ld_valid", {31'h0, o_valid}, 32'h1);
        check("ld_fields", {o_rs, o_rt, o_rd, o_shamt, o_funct}, {6'h0, 5'd3, 5'd17, 5'd31, 5'd9, 6'h21});
        check("ld_cnt", {16'h0, o_bubble_count}, exp_cnt);

        // 3. Stall holds contents and counter
        pc_plus4 = 32'h40;
        step();
        check("st_pre_pc", o_pc_plus4, 32'h40);
        stall = 1'b1; pc_plus4 = 32'h44;
        for (int i = 0; i < 3; i++) begin
            step();
            check("st_hold_pc", o_pc_plus4, 32'h40);
            check("st_hold_cnt", {16'h0, o_bubble_count}, exp_cnt);
        end
        stall = 1'b0;
        step();
        check("st_rel_pc", o_pc_plus4, 32'h44);

        // 4. Flush beats stall; invalid load is a bubble with gated ctrl
        flush = 1'b1; stall = 1'b1;
        step();
        exp_cnt++;
        check("fl_ctrl", {20'h0, o_ctrl}, 32'h0);
        check("fl_valid", {31'h0, o_valid}, 32'h0);
        check("fl_pc", o_pc_plus4, 32'h0);
        check("fl_cnt", {16'h0, o_bubble_count}, exp_cnt);
        flush = 1'b0; stall = 1'b0; valid = 1'b0; ctrl = 12'hFFF;
        step();
        exp_cnt++;
        check("inv_ctrl", {20'h0, o_ctrl}, 32'h0);
        check("inv_valid", {31'h0, o_valid}, 32'h0);
        check("inv_pc", o_pc_plus4, 32'h44);
        check("inv_cnt", {16'h0, o_bubble_count}, exp_cnt);
        valid = 1'b1;
        step();
        check("val_ctrl", {20'h0, o_ctrl}, 32'hFFF);
        check("val_cnt", {16'h0, o_bubble_count}, exp_cnt);

        // 5. Freeze ignores flush; releasing it loads the bubble
        enable = 1'b0; flush = 1'b1; pc_plus4 = 32'h99;
        for (int i = 0; i < 4; i++) begin
            step();
            check("fz_ctrl", {20'h0, o_ctrl}, 32'hFFF);
            check("fz_valid", {31'h0, o_valid}, 32'h1);
            check("fz_pc", o_pc_plus4, 32'h44);
            check("fz_cnt", {16'h0, o_bubble_count}, exp_cnt);
        end
        enable = 1'b1;
        step();
        exp_cnt++;
        check("unfz_valid", {31'h0, o_valid}, 32'h0);
        check("unfz_ctrl", {20'h0, o_ctrl}, 32'h0);
        check("unfz_cnt", {16'h0, o_bubble_count}, exp_cnt);

        // 6. Saturation on the 4-bit instance (it has seen the same bubbles)
        exp_sat = exp_cnt;
        check("sat_start", {28'h0, s_bubble_count}, exp_sat);
        for (int i = 0; i < 20; i++) begin
            step();
            exp_cnt++;
            if (exp_sat < 15) exp_sat++;
            check("sat_cnt", {28'h0, s_bubble_count}, exp_sat);
        end
        check("sat_final", {28'h0, s_bubble_count}, 32'd15);
        check("wide_cnt", {16'h0, o_bubble_count}, exp_cnt);

        // Reset mid-stall wins, then a normal load follows
        flush = 1'b0; stall = 1'b1; reset = 1'b1;
        step();
        check("rs_cnt", {16'h0, o_bubble_count}, 32'h0);
        check("rs_sat", {28'h0, s_bubble_count}, 32'h0);
        check("rs_pc", o_pc_plus4, 32'h0);
        reset = 1'b0; stall = 1'b0; valid = 1'b1; pc_plus4 = 32'h88; ctrl = 12'h003;
        step();
        check("post_rs_pc", o_pc_plus4, 32'h88);
        check("post_rs_valid", {31'h0, o_valid}, 32'h1);
        check("post_rs_ctrl", {20'h0, o_ctrl}, 32'h003);
        check("post_rs_cnt", {16'h0, o_bubble_count}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
